// File: rtl/sampler_pkg.sv
// sampler_pkg: shared widths and record types for the lease-sampler reuse table.
//   SAMPLER_TAG_BW  - identity comparator width (fixed at 20)
//   SAMPLER_TIME_BW - widest supported timestamp/interval
//   DROP_BW         - width of the saturating drop counter
//   entry_t         - one table slot {valid, tag, stamp}
//   result_t        - one retired-entry report {interval, tag, expired}
package sampler_pkg;

  localparam int unsigned SAMPLER_TAG_BW  = 20;
  localparam int unsigned SAMPLER_TIME_BW = 32;
  localparam int unsigned DROP_BW         = 16;

  // "stamp" is the sample time; "time" is a reserved word.
  typedef struct packed {
    logic                       valid;
    logic [SAMPLER_TAG_BW-1:0]  tag;
    logic [SAMPLER_TIME_BW-1:0] stamp;
  } entry_t;

  typedef struct packed {
    logic [SAMPLER_TIME_BW-1:0] interval;
    logic [SAMPLER_TAG_BW-1:0]  tag;
    logic                       expired;
  } result_t;

endpackage

// File: rtl/sampler_tag_match_bank.sv
// sampler_tag_match_bank: N_ENTRIES identity comparators gated by entry valid.
//   entry_valid  - per-slot valid bits
//   entry_tag    - per-slot stored tags
//   ref_tag      - incoming reference tag
//   match_onehot - lowest-index matching slot, one-hot (all zero on miss)
//   hit          - any slot matched
module sampler_tag_match_bank
  import sampler_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 8,
  parameter int unsigned TAG_BW    = SAMPLER_TAG_BW
) (
  input  logic [N_ENTRIES-1:0] entry_valid,
  input  logic [TAG_BW-1:0]    entry_tag [N_ENTRIES],
  input  logic [TAG_BW-1:0]    ref_tag,
  output logic [N_ENTRIES-1:0] match_onehot,
  output logic                 hit
);

  logic [N_ENTRIES-1:0] raw_match;

  always_comb begin
    raw_match = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      raw_match[i] = entry_valid[i] && (entry_tag[i] == ref_tag);
    end
  end

  // Isolate the lowest set bit so duplicate matches still yield one slot.
  assign match_onehot = raw_match & (~raw_match + N_ENTRIES'(1));
  assign hit          = |raw_match;

endmodule

// File: rtl/sampler_reuse_table.sv
// sampler_reuse_table: tracks sampled tags and reports their reuse intervals.
//   clock_i/reset_i  - rising-edge clock, synchronous active-high reset
//   req_i, req_tag_i - reference valid and tag; sample_i loads the tag
//   ready_o          - reference accepted this cycle when high with req_i
//   rui_valid_o, rui_o, rui_tag_o, rui_expired_o - one-deep result slot,
//                      held until rui_ready_i
//   drop_count_o     - saturating count of entries replaced before reuse
//   occupancy_o      - number of valid entries
// Optional build macro SAMPLER_EXPIRY_EN: retire entries whose age reaches
// EXPIRY_LIMIT as expired results; otherwise EXPIRY_LIMIT is ignored.
module sampler_reuse_table
  import sampler_pkg::*;
#(
  parameter int unsigned N_ENTRIES    = 8,
  parameter int unsigned TAG_BW       = SAMPLER_TAG_BW,
  parameter int unsigned TIME_BW      = SAMPLER_TIME_BW,
  parameter int unsigned EXPIRY_LIMIT = 2**20
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           req_i,
  input  logic [TAG_BW-1:0]              req_tag_i,
  input  logic                           sample_i,
  output logic                           ready_o,
  output logic                           rui_valid_o,
  output logic [TIME_BW-1:0]             rui_o,
  output logic [TAG_BW-1:0]              rui_tag_o,
  output logic                           rui_expired_o,
  input  logic                           rui_ready_i,
  output logic [DROP_BW-1:0]             drop_count_o,
  output logic [$clog2(N_ENTRIES):0]     occupancy_o
);

  localparam int unsigned IDX_BW = $clog2(N_ENTRIES);
  localparam int unsigned OCC_BW = IDX_BW + 1;

  entry_t               entries [N_ENTRIES];
  result_t              result_q;
  logic                 rui_valid_q;
  logic [TIME_BW-1:0]   time_now;
  logic [IDX_BW-1:0]    victim_ptr;
  logic [DROP_BW-1:0]   drop_count;

  logic [N_ENTRIES-1:0] entry_valid;
  logic [TAG_BW-1:0]    entry_tag [N_ENTRIES];
  logic [N_ENTRIES-1:0] match_onehot;
  logic                 hit;
  logic                 accept;
  logic [IDX_BW-1:0]    match_idx;
  logic [IDX_BW-1:0]    free_idx;
  logic                 any_free;
  logic [IDX_BW-1:0]    insert_idx;
  logic [TIME_BW-1:0]   hit_interval;
  logic [OCC_BW-1:0]    occ;
  logic                 exp_fire;
  logic [IDX_BW-1:0]    exp_idx;
  logic [TIME_BW-1:0]   exp_age;

  always_comb begin
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      entry_valid[i] = entries[i].valid;
      entry_tag[i]   = entries[i].tag;
    end
  end

  sampler_tag_match_bank #(
    .N_ENTRIES (N_ENTRIES),
    .TAG_BW    (TAG_BW)
  ) u_match_bank (
    .entry_valid  (entry_valid),
    .entry_tag    (entry_tag),
    .ref_tag      (req_tag_i),
    .match_onehot (match_onehot),
    .hit          (hit)
  );

  assign ready_o = !rui_valid_q || rui_ready_i;
  assign accept  = req_i && ready_o;

  always_comb begin
    match_idx = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (match_onehot[i]) match_idx = match_idx | IDX_BW'(i);
    end
  end

  // Scan downward so the last assignment is the lowest free slot.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = N_ENTRIES; i > 0; i--) begin
      if (!entry_valid[i-1]) begin
        any_free = 1'b1;
        free_idx = IDX_BW'(i-1);
      end
    end
  end

  always_comb begin
    if (hit)           insert_idx = match_idx;
    else if (any_free) insert_idx = free_idx;
    else               insert_idx = victim_ptr;
  end

  assign hit_interval = time_now - entries[match_idx].stamp[TIME_BW-1:0];

  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      occ = occ + OCC_BW'(entry_valid[i]);
    end
  end

`ifdef SAMPLER_EXPIRY_EN
  logic               exp_found;
  logic [TIME_BW-1:0] age;

  always_comb begin
    exp_found = 1'b0;
    exp_idx   = '0;
    exp_age   = '0;
    age       = '0;
    for (int unsigned i = N_ENTRIES; i > 0; i--) begin
      age = time_now - entries[i-1].stamp[TIME_BW-1:0];
      if (entries[i-1].valid && (64'(age) >= 64'(EXPIRY_LIMIT))) begin
        exp_found = 1'b1;
        exp_idx   = IDX_BW'(i-1);
        exp_age   = age;
      end
    end
  end

  // A hit owns the result slot; an expiry waits for a cycle without one.
  assign exp_fire = exp_found && ready_o && !(accept && hit);
`else
  logic unused_expiry_limit;
  assign unused_expiry_limit = (EXPIRY_LIMIT == 0);
  assign exp_fire = 1'b0;
  assign exp_idx  = '0;
  assign exp_age  = '0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) entries[i] <= '0;
      result_q    <= '0;
      rui_valid_q <= 1'b0;
      time_now    <= '0;
      victim_ptr  <= '0;
      drop_count  <= '0;
    end else begin
      if (rui_valid_q && rui_ready_i) rui_valid_q <= 1'b0;

      if (exp_fire) begin
        entries[exp_idx].valid <= 1'b0;
        result_q <= '{interval: SAMPLER_TIME_BW'(exp_age),
                      tag:      entries[exp_idx].tag,
                      expired:  1'b1};
        rui_valid_q <= 1'b1;
      end

      if (accept) begin
        time_now <= time_now + 1'b1;
        if (hit) begin
          result_q <= '{interval: SAMPLER_TIME_BW'(hit_interval),
                        tag:      req_tag_i,
                        expired:  1'b0};
          rui_valid_q <= 1'b1;
        end
        if (sample_i) begin
          entries[insert_idx] <= '{valid: 1'b1,
                                   tag:   req_tag_i,
                                   stamp: SAMPLER_TIME_BW'(time_now)};
          if (!hit && !any_free) begin
            victim_ptr <= victim_ptr + 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
          end
        end else if (hit) begin
          entries[match_idx].valid <= 1'b0;
        end
      end
    end
  end

  assign rui_valid_o   = rui_valid_q;
  assign rui_o         = result_q.interval[TIME_BW-1:0];
  assign rui_tag_o     = result_q.tag;
  assign rui_expired_o = result_q.expired;
  assign drop_count_o  = drop_count;
  assign occupancy_o   = occ;

endmodule

// File: tb/tb_sampler_reuse_table.sv
// tb_sampler_reuse_table: directed and randomized checks of sampler_reuse_table
// against a slot-level behavioural model. A second instance with an 8-bit
// timestamp exercises wraparound; with SAMPLER_EXPIRY_EN a third instance
// (EXPIRY_LIMIT=16) exercises expiry.
module tb_sampler_reuse_table;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, sample, rdy;
  logic [19:0] tag;
  logic        ready, rv, rexp;
  logic [31:0] rui;
  logic [19:0] rtag;
  logic [15:0] drop;
  logic [3:0]  occ;

  logic        w_req, w_sample, w_rdy;
  logic [19:0] w_tag;
  logic        w_ready, w_rv, w_rexp;
  logic [7:0]  w_rui;
  logic [19:0] w_rtag;
  logic [15:0] w_drop;
  logic [3:0]  w_occ;

  sampler_reuse_table #(.N_ENTRIES(N)) dut (
    .clock_i(clk), .reset_i(rst), .req_i(req), .req_tag_i(tag),
    .sample_i(sample), .ready_o(ready), .rui_valid_o(rv), .rui_o(rui),
    .rui_tag_o(rtag), .rui_expired_o(rexp), .rui_ready_i(rdy),
    .drop_count_o(drop), .occupancy_o(occ)
  );

  sampler_reuse_table #(.N_ENTRIES(N), .TIME_BW(8)) dut_w (
    .clock_i(clk), .reset_i(rst), .req_i(w_req), .req_tag_i(w_tag),
    .sample_i(w_sample), .ready_o(w_ready), .rui_valid_o(w_rv), .rui_o(w_rui),
    .rui_tag_o(w_rtag), .rui_expired_o(w_rexp), .rui_ready_i(w_rdy),
    .drop_count_o(w_drop), .occupancy_o(w_occ)
  );

`ifdef SAMPLER_EXPIRY_EN
  logic        x_req, x_sample, x_rdy;
  logic [19:0] x_tag;
  logic        x_ready, x_rv, x_rexp;
  logic [31:0] x_rui;
  logic [19:0] x_rtag;
  logic [15:0] x_drop;
  logic [3:0]  x_occ;

  sampler_reuse_table #(.N_ENTRIES(N), .EXPIRY_LIMIT(16)) dut_x (
    .clock_i(clk), .reset_i(rst), .req_i(x_req), .req_tag_i(x_tag),
    .sample_i(x_sample), .ready_o(x_ready), .rui_valid_o(x_rv), .rui_o(x_rui),
    .rui_tag_o(x_rtag), .rui_expired_o(x_rexp), .rui_ready_i(x_rdy),
    .drop_count_o(x_drop), .occupancy_o(x_occ)
  );
`endif

  // Behavioural model of the table: slots, round-robin victim, result slot.
  bit          m_v  [N];
  logic [19:0] m_t  [N];
  logic [31:0] m_ts [N];
  int          m_ptr, m_drop;
  logic [31:0] m_now;
  bit          m_rv;
  logic [31:0] m_rui;
  logic [19:0] m_rtag;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  function automatic int m_occ();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_v[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_t[i] = '0; m_ts[i] = '0; end
    m_ptr = 0; m_drop = 0; m_now = '0; m_rv = 0; m_rui = '0; m_rtag = '0;
  endtask

  task automatic check_outputs();
    chk("rui_valid_o",   rv,   m_rv);
    chk("rui_o",         rui,  m_rui);
    chk("rui_tag_o",     rtag, m_rtag);
    chk("rui_expired_o", rexp, 1'b0);
    chk("drop_count_o",  drop, 64'(m_drop));
    chk("occupancy_o",   occ,  64'(m_occ()));
  endtask

  task automatic step(input bit r, input logic [19:0] t, input bit s, input bit d);
    bit exp_ready, acc;
    int hit_i, ins;
    @(negedge clk);
    req = r; tag = t; sample = s; rdy = d;
    #1;
    exp_ready = !m_rv || d;
    chk("ready_o", ready, exp_ready);
    acc = r && exp_ready;
    if (m_rv && d) m_rv = 0;
    if (acc) begin
      hit_i = -1;
      for (int i = N - 1; i >= 0; i--) if (m_v[i] && m_t[i] == t) hit_i = i;
      if (hit_i >= 0) begin
        m_rv = 1; m_rui = m_now - m_ts[hit_i]; m_rtag = t;
        if (s) m_ts[hit_i] = m_now;
        else   m_v[hit_i]  = 0;
      end else if (s) begin
        ins = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_v[i]) ins = i;
        if (ins < 0) begin
          ins = m_ptr;
          m_ptr = (m_ptr + 1) % N;
          if (m_drop < 65535) m_drop++;
        end
        m_v[ins] = 1; m_t[ins] = t; m_ts[ins] = m_now;
      end
      m_now = m_now + 1;
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req = 0; sample = 0; rdy = 1; tag = '0;
    @(posedge clk); #1;
    model_reset();
    check_outputs();
    chk("ready_o_reset", ready, 1'b1);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit          hr, hs, d, pend;
    logic [19:0] ht;
    logic [7:0]  exp_w;

    rst = 1; req = 0; sample = 0; rdy = 1; tag = '0;
    w_req = 0; w_sample = 0; w_rdy = 1; w_tag = '0;
`ifdef SAMPLER_EXPIRY_EN
    x_req = 0; x_sample = 0; x_rdy = 1; x_tag = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Basic reuse: sample at t=0, four misses, reuse at t=5.
    step(1, 20'h12345, 1, 1);
    for (int k = 1; k <= 4; k++) step(1, 20'(k), 0, 1);
    step(1, 20'h12345, 0, 1);
    chk("basic_interval", rui, 32'd5);

    // Fill all slots, then two victims; old tags must miss.
    do_reset();
    for (int k = 0; k < N; k++) step(1, 20'h00100 + 20'(k), 1, 1);
    step(1, 20'h00200, 1, 1);
    step(1, 20'h00100, 0, 1);
    chk("victim_no_result", rv, 1'b0);
    step(1, 20'h00300, 1, 1);
    step(1, 20'h00101, 0, 1);
    chk("victim2_drop", drop, 16'd2);

    // Hit with re-arm, then reuse measured from the re-arm.
    do_reset();
    step(1, 20'hABCDE, 1, 1);
    step(1, 20'h00001, 0, 1);
    step(1, 20'h00002, 0, 1);
    step(1, 20'hABCDE, 1, 1);
    chk("rearm_interval", rui, 32'd3);
    step(1, 20'h00003, 0, 1);
    step(1, 20'hABCDE, 0, 1);
    chk("rearm_second_interval", rui, 32'd2);

    // Backpressure: result pending with downstream stalled holds the input.
    do_reset();
    step(1, 20'h0000A, 1, 0);
    step(1, 20'h0000A, 0, 0);
    step(1, 20'h0000B, 1, 0);
    step(1, 20'h0000B, 1, 0);
    step(1, 20'h0000B, 1, 1);
    chk("held_insert_occ", occ, 4'd1);

    // Randomized traffic honouring the hold-while-stalled rule.
    do_reset();
    pend = 0; hr = 0; hs = 0; ht = '0;
    for (int k = 0; k < 400; k++) begin
      if (!pend) begin
        hr = ($urandom_range(0, 9) < 8);
        ht = 20'h40000 | 20'($urandom_range(0, 11));
        hs = 1'($urandom_range(0, 1));
      end
      d = ($urandom_range(0, 3) != 0);
      pend = hr && m_rv && !d;
      step(hr, ht, hs, d);
    end

    // Reset with a result pending.
    step(1, 20'h00999, 1, 0);
    step(1, 20'h00999, 0, 0);
    do_reset();

    // Timestamp wrap on an 8-bit instance: sample at 254, reuse at 2.
    w_rdy = 1;
    for (int k = 0; k < 254; k++) begin
      @(negedge clk); w_req = 1; w_tag = 20'h00001; w_sample = 0;
    end
    @(negedge clk); w_tag = 20'h00055; w_sample = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); w_tag = 20'h00001; w_sample = 0;
    end
    @(posedge clk); #1;
    chk("wrap_before_valid", w_rv, 1'b0);
    chk("wrap_before_occ", w_occ, 4'd1);
    @(negedge clk); w_tag = 20'h00055; w_sample = 0;
    @(posedge clk); #1;
    exp_w = 8'd2 - 8'd254;
    chk("wrap_valid", w_rv, 1'b1);
    chk("wrap_interval", w_rui, exp_w);
    chk("wrap_tag", w_rtag, 20'h00055);
    chk("wrap_expired", w_rexp, 1'b0);
    chk("wrap_occ", w_occ, 4'd0);
    @(negedge clk); w_req = 0;

`ifdef SAMPLER_EXPIRY_EN
    do_reset();
    @(negedge clk); x_req = 1; x_tag = 20'h00077; x_sample = 1; x_rdy = 1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); x_tag = 20'h00001; x_sample = 0;
    end
    @(posedge clk); #1;
    chk("exp_before_valid", x_rv, 1'b0);
    @(negedge clk); x_tag = 20'h00001;
    @(posedge clk); #1;
    chk("exp_valid", x_rv, 1'b1);
    chk("exp_flag", x_rexp, 1'b1);
    chk("exp_interval", x_rui, 32'd16);
    chk("exp_tag", x_rtag, 20'h00077);
    chk("exp_occ", x_occ, 4'd0);
    @(negedge clk); x_req = 0; x_rdy = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("exp_rst_valid", x_rv, 1'b0);
    chk("exp_rst_rui", x_rui, 32'd0);
    chk("exp_rst_tag", x_rtag, 20'd0);
    chk("exp_rst_flag", x_rexp, 1'b0);
    chk("exp_rst_occ", x_occ, 4'd0);
    chk("exp_rst_drop", x_drop, 16'd0);
    @(negedge clk); rst = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
